// File: rtl/score_display_scheduler.sv
// Binary score -> 4-digit multiplexed seven-segment driver (shift-and-add-3 BCD).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero digits (ones always lit).
module score_display_scheduler #(
  parameter int REFRESH_DIV = 50000,
  parameter int SCORE_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_load,
  output logic               busy,
  output logic [3:0]         anode,
  output logic [6:0]         seg
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int               PRE_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [3:0]       SHIFT_LAST = 4'(SCORE_W - 1);
  localparam logic [13:0]      MAX_SCORE  = 14'd9999;

  logic [1:0]         state;
  logic [3:0]         shift_cnt;
  logic [SCORE_W-1:0] bin_sr;
  logic [15:0]        bcd_acc;
  logic [15:0]        bcd_adj;
  logic [15:0]        digits;
  logic [13:0]        score_ext;
  logic [13:0]        score_clamped;

  logic [PRE_W-1:0]   prescale;
  logic               tick;
  logic [1:0]         slot;
  logic [3:0]         cur_digit;
  logic [3:0]         blank;
  logic [3:0]         anode_nxt;
  logic [6:0]         seg_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0111111;
      4'd1:    seg_code = 7'b0000110;
      4'd2:    seg_code = 7'b1011011;
      4'd3:    seg_code = 7'b1001111;
      4'd4:    seg_code = 7'b1100110;
      4'd5:    seg_code = 7'b1101101;
      4'd6:    seg_code = 7'b1111101;
      4'd7:    seg_code = 7'b0000111;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1100111;
      default: seg_code = 7'b0000000;
    endcase
  endfunction

  assign score_ext     = 14'(score_in);
  assign score_clamped = (score_ext > MAX_SCORE) ? MAX_SCORE : score_ext;
  assign busy          = (state != ST_IDLE);
  assign tick          = (prescale == PRE_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < 4; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_cnt <= '0;
      bin_sr    <= '0;
      bcd_acc   <= '0;
      digits    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (score_load) begin
            bin_sr    <= score_clamped[SCORE_W-1:0];
            bcd_acc   <= '0;
            shift_cnt <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_acc   <= {bcd_adj[14:0], bin_sr[SCORE_W-1]};
          bin_sr    <= bin_sr << 1;
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == SHIFT_LAST) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // All four nibbles move together so the scan never shows a half-updated score.
          digits <= bcd_acc;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_digit = digits[3:0];
    case (slot)
      2'd0: cur_digit = digits[3:0];
      2'd1: cur_digit = digits[7:4];
      2'd2: cur_digit = digits[11:8];
      2'd3: cur_digit = digits[15:12];
      default: cur_digit = digits[3:0];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digits[15:12] == 4'd0);
    blank[2] = (digits[11:8] == 4'd0) && blank[3];
    blank[1] = (digits[7:4] == 4'd0) && blank[2];
  end
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    anode_nxt = ~(4'b0001 << slot);
    seg_nxt   = seg_code(cur_digit);
    if (blank[slot]) begin
      anode_nxt = 4'b1111;
      seg_nxt   = 7'b0000000;
    end
  end

  // Scan runs independently of the converter; it only ever reads committed digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      slot     <= 2'd0;
      anode    <= 4'b1111;
      seg      <= 7'b0000000;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      if (tick) slot <= slot + 2'd1;
      anode <= anode_nxt;
      seg   <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_score_display_scheduler.sv
// Scoreboard bench for score_display_scheduler: two instances (10-bit and 14-bit score).
module tb_score_display_scheduler;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  score_in;
  logic        score_load;
  logic        busy;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [13:0] score_in14;
  logic        load14;
  logic        busy14;
  logic [3:0]  anode14;
  logic [6:0]  seg14;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  score_display_scheduler #(.REFRESH_DIV(RD), .SCORE_W(10)) dut (
    .clk(clk), .rst(rst), .score_in(score_in), .score_load(score_load),
    .busy(busy), .anode(anode), .seg(seg)
  );

  score_display_scheduler #(.REFRESH_DIV(RD), .SCORE_W(14)) dut14 (
    .clk(clk), .rst(rst), .score_in(score_in14), .score_load(load14),
    .busy(busy14), .anode(anode14), .seg(seg14)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111};
    return tbl[d];
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [3:0] exp_blank(input logic [15:0] b);
    logic [3:0] r;
    r = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    r[3] = (b[15:12] == 0);
    r[2] = (b[11:8] == 0) && r[3];
    r[1] = (b[7:4] == 0) && r[2];
`endif
    return r;
  endfunction

  task automatic drive_load10(input int v, input bit push);
    @(negedge clk);
    score_in   = 10'(v);
    score_load = 1'b1;
    if (push) exp_q.push_back(to_bcd(v));
    @(negedge clk);
    score_load = 1'b0;
  endtask

  task automatic drive_load14(input int v);
    @(negedge clk);
    score_in14 = 14'(v);
    load14     = 1'b1;
    exp_q.push_back(to_bcd(v));
    @(negedge clk);
    load14 = 1'b0;
  endtask

  // Observe a full scan and compare every slot against the expected digits.
  task automatic check_display(input string tag, input logic [15:0] b, input bit use14);
    logic [6:0] cap [4];
    bit         seen [4];
    int         bad;
    logic [3:0] a;
    logic [6:0] s;
    logic [3:0] bl;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cap[i] = '0;
      seen[i] = 0;
    end
    for (int c = 0; c < 4 * RD + 2; c++) begin
      @(negedge clk);
      a = use14 ? anode14 : anode;
      s = use14 ? seg14 : seg;
      case (a)
        4'b1110: begin seen[0] = 1; cap[0] = s; end
        4'b1101: begin seen[1] = 1; cap[1] = s; end
        4'b1011: begin seen[2] = 1; cap[2] = s; end
        4'b0111: begin seen[3] = 1; cap[3] = s; end
        4'b1111: if (s != 7'b0) bad++;
        default: bad++;
      endcase
    end
    check({tag, "_anode_legal"}, bad, 0);
    bl = exp_blank(b);
    for (int i = 0; i < 4; i++) begin
      if (bl[i]) begin
        check($sformatf("%s_slot%0d_blank", tag, i), 32'(seen[i]), 0);
      end else begin
        check($sformatf("%s_slot%0d_lit", tag, i), 32'(seen[i]), 1);
        check($sformatf("%s_slot%0d_seg", tag, i), cap[i], seg_of(int'(b[4*i +: 4])));
      end
    end
  endtask

  // Wait for the conversion to finish, then pop the scoreboard and check the display.
  task automatic finish_load(input string tag, input bit use14, input int exp_len);
    int len;
    logic [15:0] b;
    len = 0;
    while ((use14 ? busy14 : busy) && len < 100) begin
      len++;
      @(negedge clk);
    end
    check({tag, "_busy_done"}, 32'(use14 ? busy14 : busy), 0);
    if (exp_len > 0) check({tag, "_busy_len"}, len, exp_len);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      b = exp_q.pop_front();
      check_display(tag, b, use14);
    end
  endtask

  initial begin
    logic [3:0] bl0;
    logic [3:0] exp_an;
    logic [6:0] exp_sg;
    int sl;
    rst = 1'b1; score_load = 1'b0; load14 = 1'b0; score_in = '0; score_in14 = '0;
    repeat (3) @(negedge clk);
    check("rst_anode", anode, 4'b1111);
    check("rst_seg", seg, 7'b0);
    check("rst_busy", busy, 0);
    check("rst_anode14", anode14, 4'b1111);
    rst = 1'b0;

    // T1: idle scan of zeros, 4 cycles per slot
    bl0 = exp_blank(16'h0000);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sl = (i / RD) % 4;
      exp_an = bl0[sl] ? 4'b1111 : ~(4'b0001 << sl);
      exp_sg = bl0[sl] ? 7'b0 : seg_of(0);
      check($sformatf("t1_anode_%0d", i), anode, exp_an);
      check($sformatf("t1_seg_%0d", i), seg, exp_sg);
    end

    // T2, T3
    drive_load10(357, 1);
    check("t2_busy_set", busy, 1);
    finish_load("t2", 0, 11);
    drive_load10(1023, 1);
    finish_load("t3", 0, 11);

    // T4: 14-bit clamp
    drive_load14(16383);
    finish_load("t4", 1, 15);

    // T5: load while busy is dropped
    drive_load10(357, 1);
    @(negedge clk);
    score_in = 10'd900; score_load = 1'b1;
    @(negedge clk);
    score_load = 1'b0;
    check("t5_busy_during_drop", busy, 1);
    finish_load("t5a", 0, 0);
    drive_load10(900, 1);
    finish_load("t5b", 0, 11);

    // T6: reset mid-conversion aborts and clears the display
    drive_load10(500, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_anode", anode, 4'b1111);
    check("t6_seg", seg, 7'b0);
    rst = 1'b0;
    check_display("t6_zero", 16'h0000, 0);
    drive_load10(42, 1);
    finish_load("t6_reload", 0, 11);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
